// File: rtl/cnn_pool_kxk_multi_channel.sv
// cnn_pool_kxk_multi_channel: streaming KxK valid pooling (average, optionally max) over channel-planar raster frames
// Ports: clk, reset (async, active-high); valid_in/pxl_in accept one signed pixel per qualified edge;
//        pool_mode (0 avg, 1 max) latched at each channel's first pixel; pxl_out/valid_out carry one
//        result per completed window two edges after its completing pixel; last_out marks a channel's
//        final result, frame_done the final result of the last channel.
// Macro CNN_POOL_MAX_EN compiles in the max comparator tree; without it the block always averages.
module cnn_pool_kxk_multi_channel #(
  parameter int DATA_WIDTH     = 32,
  parameter int IMAGE_WIDTH    = 16,
  parameter int IMAGE_HEIGHT   = 16,
  parameter int KERNEL         = 3,
  parameter int STRIDE         = 1,
  parameter int CHANNEL_NUM_IN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  input  logic                  pool_mode,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  last_out,
  output logic                  frame_done
);
  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);
  localparam int HW = CHANNEL_NUM_IN > 1 ? $clog2(CHANNEL_NUM_IN) : 1;
  localparam int KK = KERNEL * KERNEL;
  localparam int SW = DATA_WIDTH + $clog2(KK);
  localparam int LAST_R = KERNEL - 1 + ((IMAGE_HEIGHT - KERNEL) / STRIDE) * STRIDE;
  localparam int LAST_C = KERNEL - 1 + ((IMAGE_WIDTH - KERNEL) / STRIDE) * STRIDE;
  localparam logic signed [SW-1:0] KK_S = SW'(KK);
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [HW-1:0] ch_q, ch_d;
  logic col_end, row_end, ch_end, win_hit;
  // lb_q[0] holds the previous row, lb_q[j] the row j+1 above the current one
  logic [DATA_WIDTH-1:0] lb_q [KERNEL-1][IMAGE_WIDTH];
  // win_q[row][col]: row 0 oldest, column KERNEL-1 newest
  logic signed [DATA_WIDTH-1:0] win_q [KERNEL][KERNEL];
  logic signed [DATA_WIDTH-1:0] colv [KERNEL];
  logic v1_q, l1_q, f1_q, v2_q, l2_q, f2_q, vo_q, lo_q, fo_q;
  logic signed [SW-1:0] sum_d, sum_q;
  logic [DATA_WIDTH-1:0] res_d, out_q;
  always_comb begin
    col_end = col_q == CW'(IMAGE_WIDTH - 1);
    row_end = row_q == RW'(IMAGE_HEIGHT - 1);
    ch_end  = ch_q == HW'(CHANNEL_NUM_IN - 1);
    col_d   = col_end ? '0 : col_q + 1'b1;
    row_d   = !col_end ? row_q : row_end ? '0 : row_q + 1'b1;
    ch_d    = !(col_end && row_end) ? ch_q : ch_end ? '0 : ch_q + 1'b1;
    win_hit = row_q >= RW'(KERNEL - 1) && col_q >= CW'(KERNEL - 1) &&
              (int'(row_q) - (KERNEL - 1)) % STRIDE == 0 && (int'(col_q) - (KERNEL - 1)) % STRIDE == 0;
    colv[KERNEL-1] = pxl_in;
    for (int i = 0; i < KERNEL - 1; i++) colv[i] = lb_q[KERNEL-2-i][col_q];
    sum_d = '0;
    for (int i = 0; i < KERNEL; i++)
      for (int k = 0; k < KERNEL; k++) sum_d = sum_d + SW'(win_q[i][k]);
  end
  // Windows only complete with r,c >= K-1, so every column in win_q and every
  // line-buffer row read then belongs to the current row band and channel.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      lb_q[0][col_q] <= pxl_in;
      for (int j = 1; j < KERNEL - 1; j++) lb_q[j][col_q] <= lb_q[j-1][col_q];
      for (int i = 0; i < KERNEL; i++) begin
        for (int k = 0; k < KERNEL - 1; k++) win_q[i][k] <= win_q[i][k+1];
        win_q[i][KERNEL-1] <= colv[i];
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
      ch_q  <= '0;
      {v1_q, l1_q, f1_q, v2_q, l2_q, f2_q, vo_q, lo_q, fo_q} <= '0;
      sum_q <= '0;
      out_q <= '0;
    end else begin
      if (valid_in) begin
        col_q <= col_d;
        row_q <= row_d;
        ch_q  <= ch_d;
      end
      v1_q  <= valid_in && win_hit;
      l1_q  <= valid_in && win_hit && row_q == RW'(LAST_R) && col_q == CW'(LAST_C);
      f1_q  <= valid_in && win_hit && row_q == RW'(LAST_R) && col_q == CW'(LAST_C) && ch_end;
      v2_q  <= v1_q;
      l2_q  <= l1_q;
      f2_q  <= f1_q;
      sum_q <= sum_d;
      vo_q  <= v2_q;
      lo_q  <= l2_q;
      fo_q  <= f2_q;
      if (v2_q) out_q <= res_d;
    end
  end
`ifdef CNN_POOL_MAX_EN
  logic mode_q, m1_q, m2_q;
  logic signed [DATA_WIDTH-1:0] max_d, max_q;
  always_comb begin
    max_d = win_q[0][0];
    for (int i = 0; i < KERNEL; i++)
      for (int k = 0; k < KERNEL; k++) max_d = win_q[i][k] > max_d ? win_q[i][k] : max_d;
  end
  // The mode travels with each window so a channel change cannot retag results in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {mode_q, m1_q, m2_q} <= '0;
      max_q <= '0;
    end else begin
      if (valid_in && col_q == '0 && row_q == '0) mode_q <= pool_mode;
      m1_q  <= mode_q;
      m2_q  <= m1_q;
      max_q <= max_d;
    end
  end
  assign res_d = m2_q ? max_q : DATA_WIDTH'(sum_q / KK_S);
`else
  logic unused_mode;
  assign unused_mode = pool_mode;
  assign res_d = DATA_WIDTH'(sum_q / KK_S);
`endif
  assign pxl_out    = out_q;
  assign valid_out  = vo_q;
  assign last_out   = lo_q;
  assign frame_done = fo_q;
endmodule

// File: tb/tb_cnn_pool_kxk_multi_channel.sv
// tb_cnn_pool_kxk_multi_channel: scoreboard bench for a default and a small 4x4/K2/S2/C2 pooling instance
module tb_cnn_pool_kxk_multi_channel;
  localparam int DW = 32;
  localparam int W0 = 16, H0 = 16, K0 = 3, S0 = 1, C0 = 4;
  localparam int W1 = 4, H1 = 4, K1 = 2, S1 = 2, C1 = 2;
  typedef struct {
    logic [DW-1:0] v;
    bit last;
    bit done;
    int due;
  } exp_t;
  logic clk = 0, rst = 0;
  logic vi0 = 0, vi1 = 0, pm0 = 0, pm1 = 0;
  logic [DW-1:0] px0 = '0, px1 = '0, po0, po1;
  logic vo0, lo0, fd0, vo1, lo1, fd1;
  int cyc = 0, vectors = 0, errors = 0, n_out0 = 0;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  longint img [H0][W0];
  int mc0 = 0, mr0 = 0, mch0 = 0, mc1 = 0, mr1 = 0, mch1 = 0;
  bit lm0 = 0, max_en = 0;
  int lit[$];

  cnn_pool_kxk_multi_channel #(.DATA_WIDTH(DW), .IMAGE_WIDTH(W0), .IMAGE_HEIGHT(H0), .KERNEL(K0),
    .STRIDE(S0), .CHANNEL_NUM_IN(C0)) u_dflt (
    .clk(clk), .reset(rst), .valid_in(vi0), .pxl_in(px0), .pool_mode(pm0),
    .pxl_out(po0), .valid_out(vo0), .last_out(lo0), .frame_done(fd0));

  cnn_pool_kxk_multi_channel #(.DATA_WIDTH(DW), .IMAGE_WIDTH(W1), .IMAGE_HEIGHT(H1), .KERNEL(K1),
    .STRIDE(S1), .CHANNEL_NUM_IN(C1)) u_small (
    .clk(clk), .reset(rst), .valid_in(vi1), .pxl_in(px1), .pool_mode(pm1),
    .pxl_out(po1), .valid_out(vo1), .last_out(lo1), .frame_done(fd1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vo0) begin
      vectors++;
      n_out0++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL dflt_unexpected got=%0d cyc=%0d", $signed(po0), cyc);
      end else begin
        e0 = q0.pop_front();
        if (po0 !== e0.v || lo0 !== e0.last || fd0 !== e0.done || cyc != e0.due) begin
          errors++;
          $display("FAIL dflt_out got v=%0d last=%b done=%b cyc=%0d, want v=%0d last=%b done=%b cyc=%0d",
                   $signed(po0), lo0, fd0, cyc, $signed(e0.v), e0.last, e0.done, e0.due);
        end
      end
    end else if (lo0 || fd0) begin
      vectors++;
      errors++;
      $display("FAIL dflt_flags got last=%b done=%b want 0 without valid", lo0, fd0);
    end else if (q0.size() != 0 && cyc > q0[0].due) begin
      vectors++;
      errors++;
      $display("FAIL dflt_missing got none, want v=%0d due=%0d", $signed(q0[0].v), q0[0].due);
      q0.delete(0);
    end
    if (vo1) begin
      vectors++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL small_unexpected got=%0d cyc=%0d", $signed(po1), cyc);
      end else begin
        e1 = q1.pop_front();
        if (po1 !== e1.v || lo1 !== e1.last || fd1 !== e1.done || cyc != e1.due) begin
          errors++;
          $display("FAIL small_out got v=%0d last=%b done=%b cyc=%0d, want v=%0d last=%b done=%b cyc=%0d",
                   $signed(po1), lo1, fd1, cyc, $signed(e1.v), e1.last, e1.done, e1.due);
        end
      end
    end else if (lo1 || fd1) begin
      vectors++;
      errors++;
      $display("FAIL small_flags got last=%b done=%b want 0 without valid", lo1, fd1);
    end else if (q1.size() != 0 && cyc > q1[0].due) begin
      vectors++;
      errors++;
      $display("FAIL small_missing got none, want v=%0d due=%0d", $signed(q1[0].v), q1[0].due);
      q1.delete(0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed0(input logic [DW-1:0] p, input bit m);
    longint s, mx;
    exp_t e;
    vi0 = 1;
    px0 = p;
    pm0 = m;
    step();
    vi0 = 0;
    if (mc0 == 0 && mr0 == 0) lm0 = m;
    img[mr0][mc0] = longint'($signed(p));
    if (mr0 >= K0 - 1 && mc0 >= K0 - 1 && (mr0 - K0 + 1) % S0 == 0 && (mc0 - K0 + 1) % S0 == 0) begin
      s = 0;
      mx = img[mr0][mc0];
      for (int r = mr0 - K0 + 1; r <= mr0; r++)
        for (int c = mc0 - K0 + 1; c <= mc0; c++) begin
          s += img[r][c];
          if (img[r][c] > mx) mx = img[r][c];
        end
      e.v = (max_en && lm0) ? DW'(mx) : DW'(s / (K0 * K0));
      e.last = mr0 + S0 > H0 - 1 && mc0 + S0 > W0 - 1;
      e.done = e.last && mch0 == C0 - 1;
      e.due = cyc + 2;
      q0.push_back(e);
    end
    mc0++;
    if (mc0 == W0) begin
      mc0 = 0;
      mr0++;
      if (mr0 == H0) begin
        mr0 = 0;
        mch0 = (mch0 + 1) % C0;
      end
    end
  endtask

  task automatic feed1(input logic [DW-1:0] p, input bit m);
    exp_t e;
    vi1 = 1;
    px1 = p;
    pm1 = m;
    step();
    vi1 = 0;
    if (mr1 >= K1 - 1 && mc1 >= K1 - 1 && (mr1 - K1 + 1) % S1 == 0 && (mc1 - K1 + 1) % S1 == 0) begin
      e.v = DW'(lit.pop_front());
      e.last = mr1 + S1 > H1 - 1 && mc1 + S1 > W1 - 1;
      e.done = e.last && mch1 == C1 - 1;
      e.due = cyc + 2;
      q1.push_back(e);
    end
    mc1++;
    if (mc1 == W1) begin
      mc1 = 0;
      mr1++;
      if (mr1 == H1) begin
        mr1 = 0;
        mch1 = (mch1 + 1) % C1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    vectors++;
    if (vo0 !== 0 || po0 !== '0 || lo0 !== 0 || fd0 !== 0 || vo1 !== 0 || po1 !== '0 || lo1 !== 0 || fd1 !== 0) begin
      errors++;
      $display("FAIL reset_outputs got vo=%b/%b po=%0h/%0h lo=%b/%b fd=%b/%b want all 0",
               vo0, vo1, po0, po1, lo0, lo1, fd0, fd1);
    end
    q0.delete();
    q1.delete();
    {mc0, mr0, mch0, mc1, mr1, mch1, n_out0} = '0;
    repeat (3) step();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic rand_frame0(input int npix);
    for (int i = 0; i < npix; i++) begin
      while ($urandom_range(1) == 1) step();
      feed0($urandom, 1'($urandom_range(1)));
    end
  endtask

  initial begin
    int amax[4] = '{21, 23, 29, 31};
    int aavg[4] = '{18, 20, 26, 28};
    int nb[16] = '{-3, -3, -1, -2, -3, -3, -2, -2, 0, 0, 0, 0, 0, 0, 0, 0};
`ifdef CNN_POOL_MAX_EN
    max_en = 1;
`else
    max_en = 0;
`endif
    #1;
    do_reset();
    lit = '{2, 4, 10, 12};
    for (int i = 0; i < 4; i++) lit.push_back(max_en ? amax[i] : aavg[i]);
    for (int i = 0; i < 32; i++) feed1(i, i % 16 == 0 ? (i >= 16) : (i < 16));
    lit = '{-3, -1, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 32; i++) feed1(i < 16 ? nb[i] : 0, 0);
    rand_frame0(C0 * H0 * W0);
    rand_frame0(H0 * W0 + 38);
    do_reset();
    rand_frame0(C0 * H0 * W0);
    repeat (10) step();
    vectors++;
    if (q0.size() != 0 || q1.size() != 0 || lit.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d/%0d/%0d want 0/0/0", q0.size(), q1.size(), lit.size());
    end
    vectors++;
    if (n_out0 != C0 * ((W0 - K0) / S0 + 1) * ((H0 - K0) / S0 + 1)) begin
      errors++;
      $display("FAIL out_count got=%0d want=%0d", n_out0, C0 * ((W0 - K0) / S0 + 1) * ((H0 - K0) / S0 + 1));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish within time limit");
    $fatal(1);
  end
endmodule

// File: doc/cnn_pool_kxk_multi_channel.md
CNN_POOL_KXK_MULTI_CHANNEL -- requirements
Module: cnn_pool_kxk_multi_channel

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, pixel width; IMAGE_WIDTH, 16, columns per channel; IMAGE_HEIGHT, 16, rows per channel; KERNEL, 3, window side, legal range 2..5; STRIDE, 1, window step, legal range 1..KERNEL; CHANNEL_NUM_IN, 4, channels per frame.
REQ-002 Port clk SHALL be an input, 1 bit: the single clock; all logic rises on posedge.
REQ-003 Port reset SHALL be an input, 1 bit: asynchronous, active-high reset.
REQ-004 Port valid_in SHALL be an input, 1 bit: pxl_in is accepted on a rising clk edge where valid_in=1.
REQ-005 Port pxl_in SHALL be an input, DATA_WIDTH bits: signed two's-complement pixel.
REQ-006 Port pool_mode SHALL be an input, 1 bit: 0 selects average, 1 selects max.
REQ-007 Port pxl_out SHALL be an output, DATA_WIDTH bits: the pooled result.
REQ-008 Port valid_out SHALL be an output, 1 bit: pxl_out is valid this cycle.
REQ-009 Port last_out SHALL be an output, 1 bit: qualifies the final output of each channel.
REQ-010 Port frame_done SHALL be an output, 1 bit: qualifies the final output of the last channel.

Function
REQ-011 Input order SHALL be channel-planar raster: channel 0 rows 0..H-1, each row holding columns 0..W-1, then channel 1, and so on.
REQ-012 Column, row and channel counters SHALL advance only on accepted pixels; valid_in=0 bubbles of any length SHALL be tolerated without loss.
REQ-013 Column SHALL wrap W-1->0 and increment row; row SHALL wrap H-1->0 and increment channel; channel SHALL wrap CHANNEL_NUM_IN-1->0, after which the next frame starts with no idle cycle.
REQ-014 The block SHALL hold KERNEL-1 line buffers of IMAGE_WIDTH entries; padding is not supported ("valid" pooling only).
REQ-015 A window completes on the accepted pixel (r,c) where r>=K-1, c>=K-1, (r-K+1)%STRIDE==0 and (c-K+1)%STRIDE==0; it covers rows r-K+1..r and columns c-K+1..c of the same channel.
REQ-016 The output count SHALL be ((W-K)/STRIDE+1)*((H-K)/STRIDE+1) per channel, using integer division.
REQ-017 Latency SHALL be fixed: when the completing pixel is accepted at edge n, valid_out SHALL be high for exactly one cycle after edge n+2.
REQ-018 In average mode, the block SHALL sum the K*K samples at DATA_WIDTH+clog2(K*K) bits without overflow.
REQ-019 In average mode, the block SHALL divide the sum by K*K with truncation toward zero and truncate the result to DATA_WIDTH bits.
REQ-020 In max mode, the output SHALL be the signed maximum of the K*K samples.
REQ-021 pool_mode SHALL be sampled on the first accepted pixel of each channel (r=0, c=0) and held for that channel; changes mid-channel SHALL have no effect.
REQ-022 last_out SHALL be 1 with the final output of each channel; frame_done SHALL be 1 only with the final output of channel CHANNEL_NUM_IN-1; both SHALL be 0 whenever valid_out=0.
REQ-023 Window data SHALL never mix rows or channels across a wrap boundary.

Reset
REQ-024 While reset=1, pxl_out SHALL be 0 and valid_out, last_out and frame_done SHALL be 0, asynchronously.
REQ-025 Reset SHALL clear all counters and pipeline valid bits, and set the latched mode to average; line-buffer contents need not be cleared.
REQ-026 Reset asserted mid-frame SHALL abort the frame; the first accepted pixel after deassertion SHALL be channel 0, row 0, column 0, and no stale output SHALL appear.

Configuration
REQ-027 With macro CNN_POOL_MAX_EN defined, max mode SHALL be compiled in and REQ-020 and REQ-021 SHALL apply.
REQ-028 Without CNN_POOL_MAX_EN, the comparator tree SHALL be absent, pool_mode SHALL be ignored and the block SHALL always average; latency and all other behaviour SHALL be unchanged.

Verification
REQ-029 With W=H=4, K=2, STRIDE=2, C=2, mode=0, and channel 0 fed 0..15 contiguously: outputs SHALL be 2, 4, 10, 12, with last_out on 12 and frame_done=0.
REQ-030 Same configuration with mode=1 and CNN_POOL_MAX_EN defined: outputs SHALL be 5, 7, 13, 15; channel 1 fed 16..31 SHALL give 21, 23, 29, 31, with frame_done on 31.
REQ-031 Negative rounding, K=2: a window of -3,-3,-3,-3 SHALL give -3; a window of -1,-2,-2,-2 SHALL give -1 (sum -7 truncated toward zero).
REQ-032 Defaults (16x16, K=3, S=1, C=4) with a random valid_in duty of about 50%: each channel SHALL produce 196 outputs, each exactly 2 edges after its completing pixel, and the outputs SHALL match the golden model.
REQ-033 Reset asserted after pixel 37 of channel 1, then a full frame: no valid_out during or after reset until the new frame's first window, and the output SHALL match a clean run.
REQ-034 pool_mode toggled mid-channel: the output SHALL follow the mode latched at (0,0); without CNN_POOL_MAX_EN, mode=1 SHALL still give the averages 2, 4, 10, 12.
